// File: rtl/tsc_pkg.sv
// rtl/tsc_pkg.sv - shared types and defaults for the trigger-surround-cache dump receiver
package tsc_pkg;

  localparam int DEPTH_DEF  = 32;
  localparam int DATA_W_DEF = 8;
  localparam int TS_W_DEF   = 32;

  // Line idles low; a high bit marks the start of each sample.
  localparam logic START_BIT = 1'b1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    HUNT  = 2'd1,
    SHIFT = 2'd2,
    DONE  = 2'd3
  } state_t;

endpackage

// File: rtl/tsc_sample_ram.sv
// rtl/tsc_sample_ram.sv - sample storage, one write port and one registered read port
module tsc_sample_ram #(
  parameter int DEPTH  = 32,
  parameter int DATA_W = 8
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     wr_en,
  input  logic [$clog2(DEPTH)-1:0] wr_addr,
  input  logic [DATA_W-1:0]        wr_data,
  input  logic [$clog2(DEPTH)-1:0] rd_addr,
  output logic [DATA_W-1:0]        rd_data
);

  logic [DATA_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
  end

  // Only the output register is reset; the array keeps stale contents.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) rd_data <= '0;
    else          rd_data <= mem[rd_addr];
  end

endmodule

// File: rtl/tsc_dump_receiver.sv
// rtl/tsc_dump_receiver.sv - latches trigger time and deserializes the framed dump into sample RAM
module tsc_dump_receiver
  import tsc_pkg::*;
#(
  parameter int DEPTH  = DEPTH_DEF,
  parameter int DATA_W = DATA_W_DEF,
  parameter int TS_W   = TS_W_DEF
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     trd,
  input  logic [TS_W-1:0]          trigtm,
  input  logic                     sd,
  input  logic                     cd,
  input  logic                     clr,
  input  logic [$clog2(DEPTH)-1:0] rd_addr,
  output logic [DATA_W-1:0]        rd_data,
  output logic [TS_W-1:0]          trig_time,
  output logic [$clog2(DEPTH):0]   byte_count,
  output logic                     busy,
  output logic                     frame_done,
  output logic                     short_err,
  output logic                     ovf_err
);

  localparam int AW = $clog2(DEPTH);
  localparam int BW = (DATA_W > 1) ? $clog2(DATA_W) : 1;
  localparam logic [BW-1:0] LAST_BIT = BW'(DATA_W - 1);
  localparam logic [AW:0]   FULL     = (AW + 1)'(DEPTH);

  state_t            state, state_next;
  logic [BW-1:0]     bit_cnt;
  logic [DATA_W-1:0] shreg;
  logic [DATA_W-1:0] shift_word;
  logic              start_frame, byte_done, wr_en, to_done, abort, clr_flags;

  assign shift_word = {shreg[DATA_W-2:0], sd};
  assign busy       = (state == HUNT) || (state == SHIFT);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_next;
  end

  always_comb begin
    state_next  = state;
    start_frame = 1'b0;
    byte_done   = 1'b0;
    wr_en       = 1'b0;
    to_done     = 1'b0;
    abort       = 1'b0;
    clr_flags   = 1'b0;
    case (state)
      IDLE: begin
        if (trd) begin
          state_next  = HUNT;
          start_frame = 1'b1;
        end
      end
      HUNT: begin
        if (cd) begin
          state_next = DONE;
          to_done    = 1'b1;
        end else if (sd == START_BIT) begin
          state_next = SHIFT;
        end
      end
      SHIFT: begin
        // A close request discards any partially assembled sample.
        if (cd) begin
          state_next = DONE;
          to_done    = 1'b1;
          abort      = 1'b1;
        end else if (bit_cnt == LAST_BIT) begin
          state_next = HUNT;
          byte_done  = 1'b1;
          wr_en      = (byte_count < FULL);
        end
      end
      DONE: begin
        if (trd) begin
          state_next  = HUNT;
          start_frame = 1'b1;
        end else if (clr) begin
          state_next = IDLE;
          clr_flags  = 1'b1;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      bit_cnt    <= '0;
      shreg      <= '0;
      trig_time  <= '0;
      byte_count <= '0;
      frame_done <= 1'b0;
      short_err  <= 1'b0;
      ovf_err    <= 1'b0;
    end else begin
      if (state == SHIFT) begin
        shreg   <= shift_word;
        bit_cnt <= bit_cnt + BW'(1);
      end else begin
        bit_cnt <= '0;
      end
      if (start_frame) begin
        trig_time  <= trigtm;
        byte_count <= '0;
        frame_done <= 1'b0;
        short_err  <= 1'b0;
        ovf_err    <= 1'b0;
      end
      if (clr_flags) begin
        frame_done <= 1'b0;
        short_err  <= 1'b0;
        ovf_err    <= 1'b0;
      end
      if (byte_done) begin
        if (wr_en) byte_count <= byte_count + (AW + 1)'(1);
        else       ovf_err    <= 1'b1;
      end
      if (to_done) begin
        frame_done <= 1'b1;
        if (abort || (byte_count != FULL)) short_err <= 1'b1;
      end
    end
  end

  tsc_sample_ram #(
    .DEPTH  (DEPTH),
    .DATA_W (DATA_W)
  ) u_ram (
    .clk     (clk),
    .reset_n (reset_n),
    .wr_en   (wr_en),
    .wr_addr (byte_count[AW-1:0]),
    .wr_data (shift_word),
    .rd_addr (rd_addr),
    .rd_data (rd_data)
  );

endmodule

// File: tb/tb_tsc_dump_receiver.sv
// tb/tb_tsc_dump_receiver.sv - directed frame table plus hand sequences for abort, retrigger and reset
module tb_tsc_dump_receiver;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        trd;
  logic [31:0] trigtm;
  logic        sd;
  logic        cd;
  logic        clr;
  logic [4:0]  rd_addr;
  logic [7:0]  rd_data;
  logic [31:0] trig_time;
  logic [5:0]  byte_count;
  logic        busy;
  logic        frame_done;
  logic        short_err;
  logic        ovf_err;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  tsc_dump_receiver dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .trd        (trd),
    .trigtm     (trigtm),
    .sd         (sd),
    .cd         (cd),
    .clr        (clr),
    .rd_addr    (rd_addr),
    .rd_data    (rd_data),
    .trig_time  (trig_time),
    .byte_count (byte_count),
    .busy       (busy),
    .frame_done (frame_done),
    .short_err  (short_err),
    .ovf_err    (ovf_err)
  );

  typedef struct {
    string       name;
    int          n_bytes;
    logic [7:0]  first;
    logic [31:0] ts;
    logic        clr_too;
    int          exp_count;
    logic        exp_short;
    logic        exp_ovf;
    logic [4:0]  addr;
    logic [7:0]  exp_data;
  } frame_vec_t;

  frame_vec_t vecs [4];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b);
    sd = 1'b1;
    tick();
    for (int i = 7; i >= 0; i--) begin
      sd = b[i];
      tick();
    end
  endtask

  task automatic start_frame(input logic [31:0] ts, input logic with_clr);
    trd    = 1'b1;
    trigtm = ts;
    clr    = with_clr;
    tick();
    trd = 1'b0;
    clr = 1'b0;
  endtask

  task automatic close_frame();
    sd = 1'b0;
    cd = 1'b1;
    tick();
    cd = 1'b0;
  endtask

  task automatic read_check(input string name, input logic [4:0] a, input logic [7:0] exp);
    rd_addr = a;
    tick();
    check(name, 32'(rd_data), 32'(exp));
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, " rd_data"},    32'(rd_data),    0);
    check({tag, " trig_time"},  trig_time,       0);
    check({tag, " byte_count"}, 32'(byte_count), 0);
    check({tag, " busy"},       32'(busy),       0);
    check({tag, " frame_done"}, 32'(frame_done), 0);
    check({tag, " short_err"},  32'(short_err),  0);
    check({tag, " ovf_err"},    32'(ovf_err),    0);
  endtask

  initial begin
    vecs[0] = '{"full",     32, 8'h00, 32'h0000_1234, 1'b0, 32, 1'b0, 1'b0, 5'd5,  8'h05};
    vecs[1] = '{"short",    10, 8'h40, 32'h0000_5678, 1'b1, 10, 1'b1, 1'b0, 5'd9,  8'h49};
    vecs[2] = '{"overflow", 34, 8'hA0, 32'hDEAD_BEEF, 1'b0, 32, 1'b0, 1'b1, 5'd31, 8'hBF};
    vecs[3] = '{"empty",     0, 8'h00, 32'h0000_0077, 1'b0,  0, 1'b1, 1'b0, 5'd31, 8'hBF};

    reset_n = 1'b0;
    trd = 1'b0; trigtm = '0; sd = 1'b0; cd = 1'b0; clr = 1'b0; rd_addr = '0;
    tick();
    tick();
    check_all_zero("reset");
    reset_n = 1'b1;
    tick();

    for (int v = 0; v < 4; v++) begin
      start_frame(vecs[v].ts, vecs[v].clr_too);
      check({vecs[v].name, " busy"},      32'(busy),       1);
      check({vecs[v].name, " trig_time"}, trig_time,       vecs[v].ts);
      check({vecs[v].name, " start cnt"}, 32'(byte_count), 0);
      for (int k = 0; k < vecs[v].n_bytes; k++) send_byte(vecs[v].first + 8'(k));
      close_frame();
      check({vecs[v].name, " frame_done"}, 32'(frame_done), 1);
      check({vecs[v].name, " busy off"},   32'(busy),       0);
      check({vecs[v].name, " byte_count"}, 32'(byte_count), 32'(vecs[v].exp_count));
      check({vecs[v].name, " short_err"},  32'(short_err),  32'(vecs[v].exp_short));
      check({vecs[v].name, " ovf_err"},    32'(ovf_err),    32'(vecs[v].exp_ovf));
      read_check({vecs[v].name, " rd_data"}, vecs[v].addr, vecs[v].exp_data);
    end

    // Mid-byte abort: three whole samples then cd after three data bits.
    start_frame(32'h0000_0A0A, 1'b0);
    send_byte(8'h10);
    send_byte(8'h11);
    send_byte(8'h12);
    sd = 1'b1;
    for (int i = 0; i < 4; i++) tick();
    close_frame();
    check("abort byte_count", 32'(byte_count), 3);
    check("abort short_err",  32'(short_err),  1);
    check("abort frame_done", 32'(frame_done), 1);
    read_check("abort mem3 kept", 5'd3, 8'hA3);
    read_check("abort mem2",      5'd2, 8'h12);

    // Retrigger in HUNT is ignored, then clr and idle-line noise.
    start_frame(32'h0000_AAAA, 1'b0);
    trd = 1'b1;
    trigtm = 32'h0000_5555;
    tick();
    trd = 1'b0;
    check("hunt trd trig_time", trig_time, 32'h0000_AAAA);
    check("hunt trd busy",      32'(busy), 1);
    close_frame();
    clr = 1'b1;
    tick();
    clr = 1'b0;
    check("clr frame_done", 32'(frame_done), 0);
    check("clr short_err",  32'(short_err),  0);
    check("clr ovf_err",    32'(ovf_err),    0);
    check("clr busy",       32'(busy),       0);
    send_byte(8'h77);
    sd = 1'b0;
    tick();
    check("idle noise busy",       32'(busy),       0);
    check("idle noise byte_count", 32'(byte_count), 0);
    check("idle noise frame_done", 32'(frame_done), 0);
    read_check("idle noise mem0", 5'd0, 8'h10);

    // Asynchronous reset in the middle of a sample.
    start_frame(32'h0000_C0DE, 1'b0);
    send_byte(8'h21);
    send_byte(8'h22);
    sd = 1'b1;
    tick();
    sd = 1'b0;
    tick();
    sd = 1'b1;
    tick();
    #2;
    reset_n = 1'b0;
    #1;
    check_all_zero("async reset");
    sd = 1'b0;
    tick();
    tick();
    reset_n = 1'b1;
    tick();
    check("post reset busy", 32'(busy), 0);
    start_frame(32'h0000_BEEF, 1'b0);
    check("restart trig_time", trig_time, 32'h0000_BEEF);
    check("restart busy",      32'(busy), 1);
    send_byte(8'h5A);
    close_frame();
    check("restart byte_count", 32'(byte_count), 1);
    check("restart frame_done", 32'(frame_done), 1);
    check("restart short_err",  32'(short_err),  1);
    read_check("restart mem0", 5'd0, 8'h5A);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/tsc_dump_receiver.md
# tsc_dump_receiver

Receiving end of the trigger-surround-cache serial dump. Watches the cache's trigger-detect strobe and latches the trigger timestamp. Deserializes the framed bit stream on `sd` into a 32-entry sample memory, then flags completion when the cache raises `cd`. Sits between the cache and the host/readout logic, which reads captured samples through a synchronous read port.

## Interface
- `DEPTH`, 32, number of sample slots (power of two)
- `DATA_W`, 8, bits per sample (matches ADC width)
- `TS_W`, 32, trigger timestamp width
- `clk`  in  1  system clock; all logic on rising edge
- `reset_n`  in  1  asynchronous, active-low reset
- `trd`  in  1  trigger detected, from cache
- `trigtm`  in  TS_W  trigger time, valid while `trd`=1
- `sd`  in  1  serial dump data, one bit per clk
- `cd`  in  1  dump complete, from cache
- `clr`  in  1  one-cycle pulse; clears `frame_done` and error flags
- `rd_addr`  in  log2(DEPTH)  read address
- `rd_data`  out  DATA_W  registered read data
- `trig_time`  out  TS_W  latched timestamp
- `byte_count`  out  log2(DEPTH)+1  samples captured this frame
- `busy`  out  1  capture in progress (HUNT or SHIFT)
- `frame_done`  out  1  frame closed by `cd`
- `short_err`  out  1  frame closed with fewer than DEPTH samples, or mid-byte
- `ovf_err`  out  1  more than DEPTH samples received

## Operation
- Serial frame: `sd` idles 0; each sample is a start bit (1) followed by DATA_W data bits, MSB first, one bit per clk. There are no stop bits, and samples may be back-to-back.
- States: IDLE, HUNT, SHIFT, DONE.
- IDLE: `trd`=1 latches `trigtm` into `trig_time`, zeroes `byte_count`, clears errors, and moves to HUNT.
- HUNT: `sd`=1 moves to SHIFT with `bit_cnt`=0. `cd`=1 moves to DONE. If both occur in the same cycle, `cd` wins.
- SHIFT: shifts `sd` into the shift register each cycle. After the DATA_W-th bit:
  - if `byte_count` < DEPTH: write to `mem[byte_count]` and increment `byte_count`;
  - otherwise set `ovf_err` and drop the byte;
  - return to HUNT.
- SHIFT with `cd`=1 before the byte completes: discard the partial byte, set `short_err`, go to DONE.
- Entering DONE: set `frame_done`; set `short_err` if `byte_count` != DEPTH.
- DONE: `clr` returns to IDLE and clears the flags. `trd`=1 restarts directly, as in IDLE; the previous frame's data is overwritten. If `clr` and `trd` occur together, `trd` wins.
- `trd` in HUNT/SHIFT is ignored; `trig_time` is held.
- `busy` = state is HUNT or SHIFT.
- The memory is not reset. Reads at or above `byte_count` return whatever was last written.

## Timing
- Reset: state IDLE; all outputs 0 (`rd_data`, `trig_time`, `byte_count`, `busy`, `frame_done`, `short_err`, `ovf_err`).
- Start bit sampled at edge t; data bits at t+1..t+DATA_W. Memory write and `byte_count` update occur at the t+DATA_W edge and are visible at t+DATA_W+1.
- The earliest next start bit is sampled at t+DATA_W+1; this is the back-to-back case.
- `rd_data` = `mem[rd_addr]` one cycle after `rd_addr` is presented. Reads are allowed at any time. If a read and a write hit the same address in the same cycle, the read returns old data.
- `frame_done` asserts one cycle after `cd` is sampled and is a level output.
- `trig_time` is captured on the same edge at which `trd` is sampled in IDLE/DONE.
- When `reset_n` falls mid-frame, the block aborts immediately to reset values. The next `trd` after release starts a fresh frame.

## Structure
- Shared package `tsc_pkg`: state enum (IDLE/HUNT/SHIFT/DONE), `DEPTH`/`DATA_W`/`TS_W` defaults, and the start-bit polarity constant.
- Sub-module `tsc_sample_ram`: DEPTH×DATA_W, one write port and one registered read port, no reset. The FSM, shifter and counters stay in the top level.

## Test plan
- Full frame:
  - Stimulus: `trd` with `trigtm`=0x0000_1234, then 32 framed bytes 0x00..0x1F back-to-back, then `cd`.
  - Required: `trig_time`=0x1234, `byte_count`=32, `frame_done`=1, no errors, `rd_addr`=5 gives `rd_data`=0x05.
- Short frame:
  - Stimulus: 10 bytes, then `cd`.
  - Required: `byte_count`=10, `short_err`=1, `frame_done`=1.
- Mid-byte abort:
  - Stimulus: `cd` after 3 data bits of byte 4.
  - Required: `byte_count`=3, `short_err`=1, `mem[3]` unchanged.
- Overflow:
  - Stimulus: 34 bytes (0xA0..), then `cd`.
  - Required: `ovf_err`=1, `byte_count`=32, `mem[31]`=0xBF.
- Idle noise and retrigger:
  - Stimulus: `sd` pulses while IDLE; `trd` while in HUNT; then `clr`.
  - Required: no capture while IDLE; `trig_time` unchanged by the HUNT `trd`; `clr` returns flags to 0.
- Async reset mid-SHIFT:
  - Stimulus: drop `reset_n` during SHIFT.
  - Required: all outputs 0 immediately; a following `trd` begins a new frame.
